// File: rtl/sbox_share_ctrl.sv
// sbox_share_ctrl: time-shares LANES AES S-boxes between SubBytes and SubWord jobs.
// Define SBOX_SHARE_RR_EN for round-robin arbitration; fixed word priority otherwise.
module sbox_share_ctrl #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_data,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out_data,
    input  logic         wd_valid,
    output logic         wd_ready,
    input  logic [31:0]  wd_data,
    output logic         wd_out_valid,
    input  logic         wd_out_ready,
    output logic [31:0]  wd_out_data,
    output logic         busy
);
    localparam int ST_BEATS = 16 / LANES;
    localparam int WD_BEATS = (LANES >= 4) ? 1 : 4 / LANES;
    localparam int WD_LANES = (LANES > 4) ? 4 : LANES;

    // S-box table, byte 0x00 at the MSB end
    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN_ST, RUN_WD} state_e;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [127:0]   work_q, work_d;
    logic           st_ov_q, st_ov_d;
    logic           wd_ov_q, wd_ov_d;
    logic [127:0]   st_res_q, st_res_d;
    logic [31:0]    wd_res_q, wd_res_d;
    logic           st_ok, wd_ok, st_win, wd_win, last, wd_pref;
    logic [3:0]     bidx [LANES];
    logic [7:0]     sb_in [LANES];
    logic [7:0]     sb_out [LANES];

`ifdef SBOX_SHARE_RR_EN
    logic rr_q, rr_d;

    // rr_q high means the word requester wins the next tie
    always_comb begin
        rr_d = rr_q;
        if (wd_win) rr_d = 1'b0;
        else if (st_win) rr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b1;
        else rr_q <= rr_d;
    end

    assign wd_pref = rr_q;
`else
    assign wd_pref = 1'b1;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign bidx[l]   = 4'(cnt_q * 4'(LANES) + 4'(l));
        assign sb_in[l]  = work_q[{bidx[l], 3'b000} +: 8];
        assign sb_out[l] = SBOX[{~sb_in[l], 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wd_win) state_d = RUN_WD;
                else if (st_win) state_d = RUN_ST;
            end
            RUN_ST, RUN_WD: if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The loser of a tie sees its ready masked by the winner's request
    always_comb begin
        st_ok    = (state_q == IDLE) && !st_ov_q;
        wd_ok    = (state_q == IDLE) && !wd_ov_q;
        wd_win   = wd_ok && wd_valid && (wd_pref || !(st_ok && st_valid));
        st_win   = st_ok && st_valid && !wd_win;
        st_ready = st_ok && !wd_win;
        wd_ready = wd_ok && !st_win;
        busy     = (state_q != IDLE);
        last     = (state_q == RUN_ST) ? (cnt_q == 4'(ST_BEATS - 1))
                                       : (cnt_q == 4'(WD_BEATS - 1));
    end

    always_comb begin
        cnt_d    = cnt_q;
        work_d   = work_q;
        st_ov_d  = st_ov_q && !st_out_ready;
        wd_ov_d  = wd_ov_q && !wd_out_ready;
        st_res_d = st_res_q;
        wd_res_d = wd_res_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (wd_win) work_d = {96'b0, wd_data};
            else if (st_win) work_d = st_data;
        end else begin
            cnt_d = cnt_q + 4'd1;
            for (int l = 0; l < LANES; l++) begin
                if (state_q == RUN_ST || l < WD_LANES)
                    work_d[{bidx[l], 3'b000} +: 8] = sb_out[l];
            end
            if (last) begin
                cnt_d = '0;
                if (state_q == RUN_ST) begin
                    st_ov_d  = 1'b1;
                    st_res_d = work_d;
                end else begin
                    wd_ov_d  = 1'b1;
                    wd_res_d = work_d[31:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            work_q   <= '0;
            st_ov_q  <= 1'b0;
            wd_ov_q  <= 1'b0;
            st_res_q <= '0;
            wd_res_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            st_ov_q  <= st_ov_d;
            wd_ov_q  <= wd_ov_d;
            st_res_q <= st_res_d;
            wd_res_q <= wd_res_d;
        end
    end

    assign st_out_valid = st_ov_q;
    assign st_out_data  = st_res_q;
    assign wd_out_valid = wd_ov_q;
    assign wd_out_data  = wd_res_q;

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// tb_sbox_share_ctrl: directed vectors and corner sequences for sbox_share_ctrl.
// Instance 0 uses LANES=4; instances 1..4 sweep LANES=1,2,8,16.
module tb_sbox_share_ctrl;
    localparam int NI = 5;
    localparam int LN [NI] = '{4, 1, 2, 8, 16};
`ifdef SBOX_SHARE_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         st_valid [NI];
    logic         st_ready [NI];
    logic [127:0] st_data [NI];
    logic         st_out_valid [NI];
    logic         st_out_ready [NI];
    logic [127:0] st_out_data [NI];
    logic         wd_valid [NI];
    logic         wd_ready [NI];
    logic [31:0]  wd_data [NI];
    logic         wd_out_valid [NI];
    logic         wd_out_ready [NI];
    logic [31:0]  wd_out_data [NI];
    logic         busy [NI];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sbox_share_ctrl #(.LANES(LN[g])) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .st_valid     (st_valid[g]),
            .st_ready     (st_ready[g]),
            .st_data      (st_data[g]),
            .st_out_valid (st_out_valid[g]),
            .st_out_ready (st_out_ready[g]),
            .st_out_data  (st_out_data[g]),
            .wd_valid     (wd_valid[g]),
            .wd_ready     (wd_ready[g]),
            .wd_data      (wd_data[g]),
            .wd_out_valid (wd_out_valid[g]),
            .wd_out_ready (wd_out_ready[g]),
            .wd_out_data  (wd_out_data[g]),
            .busy         (busy[g])
        );
    end

    // Reference S-box from GF(2^8) inversion and the AES affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01;
        if (a == 8'h00) r = 8'h00;
        else for (int i = 0; i < 254; i++) r = gmul(r, a);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox(x[8*i +: 8]);
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_job(input int d, input bit isst, input logic [127:0] din,
                           output logic [127:0] res, output int lat);
        int  n = 0;
        bit  ov;
        @(negedge clk);
        if (isst) begin
            st_valid[d] = 1'b1;
            st_data[d]  = din;
        end else begin
            wd_valid[d] = 1'b1;
            wd_data[d]  = din[31:0];
        end
        #1;
        while (!(isst ? st_ready[d] : wd_ready[d]) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check($sformatf("inst%0d ready", d), 128'(isst ? st_ready[d] : wd_ready[d]), 128'd1);
        @(posedge clk);
        #1;
        st_valid[d] = 1'b0;
        wd_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            ov = isst ? st_out_valid[d] : wd_out_valid[d];
        end while (!ov && lat < 40);
        res = isst ? st_out_data[d] : {96'b0, wd_out_data[d]};
    endtask

    task automatic tie_once(input bit exp_wd, input string nm);
        bit gs = 1'b0;
        bit gw = 1'b0;
        @(negedge clk);
        st_valid[0] = 1'b1;
        wd_valid[0] = 1'b1;
        st_data[0]  = {4{$urandom}};
        wd_data[0]  = $urandom;
        #1;
        check({nm, " st_ready"}, 128'(st_ready[0]), 128'(!exp_wd));
        check({nm, " wd_ready"}, 128'(wd_ready[0]), 128'(exp_wd));
        @(posedge clk);
        #1;
        st_valid[0] = 1'b0;
        wd_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            gs |= st_out_valid[0];
            gw |= wd_out_valid[0];
        end
        check({nm, " winner"}, 128'({gw, gs}), 128'(exp_wd ? 2'b10 : 2'b01));
    endtask

    typedef struct {
        bit           st;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res, exp, din;
        int           lat;
        bit           flag;
        int           ng;
        logic [3:0]   seq;
        int           st_lat [4] = '{16, 8, 2, 1};
        int           wd_lat [4] = '{4, 2, 1, 1};

        vt[0] = '{1'b1, 128'h0, {16{8'h63}}};
        vt[1] = '{1'b0, 128'h00010203, 128'h637c777b};
        vt[2] = '{1'b0, 128'h53ff0000, 128'hed166363};
        vt[3] = '{1'b1, 128'h0f0e0d0c0b0a09080706050403020100,
                  128'h76abd7fe2b670130c56f6bf27b777c63};
        vt[4] = '{1'b1, {16{8'hff}}, {16{8'h16}}};
        vt[5] = '{1'b0, 128'hffff5300, 128'h1616ed63};

        for (int i = 0; i < NI; i++) begin
            st_valid[i]     = 1'b0;
            wd_valid[i]     = 1'b0;
            st_data[i]      = '0;
            wd_data[i]      = '0;
            st_out_ready[i] = 1'b1;
            wd_out_ready[i] = 1'b1;
        end
        do_reset();

        check("rst busy", 128'(busy[0]), 128'd0);
        check("rst st_out_valid", 128'(st_out_valid[0]), 128'd0);
        check("rst wd_out_valid", 128'(wd_out_valid[0]), 128'd0);
        check("rst st_out_data", st_out_data[0], 128'd0);
        check("rst wd_out_data", 128'(wd_out_data[0]), 128'd0);
        check("rst readies", 128'({st_ready[0], wd_ready[0]}), 128'(2'b11));

        // busy window and 4-beat latency of a state job
        @(negedge clk);
        st_data[0]  = '0;
        st_valid[0] = 1'b1;
        #1;
        check("busy seq st_ready", 128'(st_ready[0]), 128'd1);
        @(posedge clk);
        #1;
        st_valid[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("busy beat%0d", i), 128'(busy[0]), 128'd1);
            check($sformatf("no result beat%0d", i), 128'(st_out_valid[0]), 128'd0);
            @(posedge clk);
            #1;
        end
        check("busy seq out_valid", 128'(st_out_valid[0]), 128'd1);
        check("busy seq busy low", 128'(busy[0]), 128'd0);
        check("busy seq data", st_out_data[0], {16{8'h63}});
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_job(0, vt[i].st, vt[i].din, res, lat);
            check($sformatf("vec%0d data", i), res, vt[i].exp);
            check($sformatf("vec%0d latency", i), 128'(lat), 128'(vt[i].st ? 4 : 1));
        end

        // both requesters held valid; drained outputs let them interleave
        do_reset();
        st_valid[0] = 1'b1;
        wd_valid[0] = 1'b1;
        st_data[0]  = '0;
        wd_data[0]  = 32'h00010203;
        ng   = 0;
        seq  = '0;
        flag = 1'b0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (st_ready[0] && wd_ready[0]) flag = 1'b1;
            if (wd_ready[0]) begin
                seq[3 - ng] = 1'b1;
                ng++;
            end else if (st_ready[0]) begin
                ng++;
            end
            @(negedge clk);
        end
        st_valid[0] = 1'b0;
        wd_valid[0] = 1'b0;
        check("hold grant order", 128'(seq), 128'(4'b1010));
        check("hold grant count", 128'(ng), 128'd4);
        check("hold dual ready", 128'(flag), 128'd0);
        repeat (8) @(negedge clk);

        do_reset();
        tie_once(1'b1, "tie0");
        tie_once(!RR, "tie1");
        tie_once(1'b1, "tie2");
        tie_once(!RR, "tie3");

        // backpressure on the state output
        st_out_ready[0] = 1'b0;
        din = {$urandom, $urandom, $urandom, $urandom};
        exp = ref_sub(din);
        run_job(0, 1'b1, din, res, lat);
        check("bp st data", res, exp);
        check("bp st latency", 128'(lat), 128'd4);
        run_job(0, 1'b0, 128'h8899aabb, res, lat);
        check("bp wd data", res, ref_sub(128'h8899aabb) & 128'hffffffff);
        check("bp wd latency", 128'(lat), 128'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("bp hold%0d", i), 128'({st_out_valid[0], st_ready[0]}), 128'(2'b10));
            check($sformatf("bp data%0d", i), st_out_data[0], exp);
        end
        @(negedge clk);
        st_out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", 128'(st_out_valid[0]), 128'd0);
        check("bp release data", st_out_data[0], exp);
        check("bp release ready", 128'(st_ready[0]), 128'd1);

        // asynchronous reset during beat 2 of a state job
        @(negedge clk);
        st_data[0]  = 128'h0123456789abcdef0123456789abcdef;
        st_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        st_valid[0] = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst busy", 128'(busy[0]), 128'd0);
        check("arst valids", 128'({st_out_valid[0], wd_out_valid[0]}), 128'd0);
        check("arst st data", st_out_data[0], 128'd0);
        check("arst wd data", 128'(wd_out_data[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            flag |= st_out_valid[0];
        end
        check("arst no result", 128'(flag), 128'd0);
        din = 128'h00112233445566778899aabbccddeeff;
        run_job(0, 1'b1, din, res, lat);
        check("arst fresh data", res, ref_sub(din));
        check("arst fresh latency", 128'(lat), 128'd4);

        for (int d = 1; d < NI; d++) begin
            for (int r = 0; r < 2; r++) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                run_job(d, 1'b1, din, res, lat);
                check($sformatf("L%0d st data r%0d", LN[d], r), res, ref_sub(din));
                check($sformatf("L%0d st lat r%0d", LN[d], r), 128'(lat), 128'(st_lat[d-1]));
                din = {96'b0, 32'($urandom)};
                run_job(d, 1'b0, din, res, lat);
                check($sformatf("L%0d wd data r%0d", LN[d], r), res,
                      ref_sub(din) & 128'hffffffff);
                check($sformatf("L%0d wd lat r%0d", LN[d], r), 128'(lat), 128'(wd_lat[d-1]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
